regfile_param: RTL and testbench

Parametrised general-purpose register file for the pipeline's ID stage, the next generation of the fixed 32×32 two-port register bank. It provides NUM_READ registered read ports, one write port with optional write-to-read bypass and an optional hard-wired zero register. In place of 32 parallel debug buses, it has a serial dump port with a valid/ready handshake, which feeds the UART debug unit one register per transfer.

---
 rtl/regfile_pkg.sv | 45 ++++
 rtl/regfile_dump_ctrl.sv | 102 ++++++++++
 rtl/regfile_param.sv | 101 ++++++++++
 tb/tb_regfile_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types, defaults and capture rule for the register file
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int c_def_data_width = 32;
    localparam int c_def_addr_width = 5;
    // Addresses are zero-extended to this width before reaching capture_src
    localparam int c_cap_aw         = 16;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

    typedef enum logic [1:0] {
        CAP_ARRAY = 2'd0,
        CAP_WRITE = 2'd1,
        CAP_ZERO  = 2'd2
    } cap_src_e;

    // Zero register wins over bypass, so a write to register 0 never leaks out
    function automatic cap_src_e capture_src(
        input logic                zero_reg,
        input logic                bypass,
        input logic                wr_en,
        input logic [c_cap_aw-1:0] wr_addr,
        input logic [c_cap_aw-1:0] rd_addr
    );
        if (zero_reg && (rd_addr == '0)) begin
            return CAP_ZERO;
        end
        if (bypass && wr_en && (rd_addr == wr_addr)) begin
            return CAP_WRITE;
        end
        return CAP_ARRAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
// ============================================================================
// regfile_dump_ctrl : serial dump FSM, index counter and valid/ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] req_index_o,
    input  logic [DATA_WIDTH-1:0] req_word_i,
    output logic                  dump_busy,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_done
);

    // The last register index is DEPTH-1, i.e. all ones
    localparam logic [ADDR_WIDTH-1:0] c_last_idx = '1;

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  w_xfer;

    assign w_xfer = valid_q && dump_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        req_index_o = '0;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_SEND;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = req_word_i;
                end
            end
            DUMP_SEND: begin
                if (w_xfer) begin
                    if (idx_q == c_last_idx) begin
                        state_d = DUMP_DONE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        req_index_o = idx_q + ADDR_WIDTH'(1);
                        idx_d       = req_index_o;
                        data_d      = req_word_i;
                    end
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != DUMP_IDLE);
            done_q  <= (state_d == DUMP_DONE);
        end
    end

    assign dump_busy  = busy_q;
    assign dump_valid = valid_q;
    assign dump_index = idx_q;
    assign dump_data  = data_q;
    assign dump_done  = done_q;

endmodule

`default_nettype wire

// File: rtl/regfile_param.sv
// ============================================================================
// regfile_param : parametrised register file, registered read ports, serial dump
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    input  logic                           reg_write,
    input  logic [ADDR_WIDTH-1:0]          write_address,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           dump_start,
    output logic                           dump_busy,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic [ADDR_WIDTH-1:0]          dump_index,
    output logic [DATA_WIDTH-1:0]          dump_data,
    output logic                           dump_done
);

    localparam int   c_depth = 2 ** ADDR_WIDTH;
    localparam logic c_zero  = (ZERO_REG != 0);
    localparam logic c_byp   = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_q [c_depth];
    logic                  w_wr_ok;
    logic [ADDR_WIDTH-1:0] w_dump_req_idx;
    logic [DATA_WIDTH-1:0] w_dump_word;

    assign w_wr_ok = reg_write && !(c_zero && (write_address == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            regs_q[write_address] <= write_data;
        end
    end

    // Value a read port or the dump path latches at this edge for address a
    function automatic logic [DATA_WIDTH-1:0] capture_word(input logic [ADDR_WIDTH-1:0] a);
        case (capture_src(c_zero, c_byp, reg_write,
                          c_cap_aw'(write_address), c_cap_aw'(a)))
            CAP_ZERO:  return '0;
            CAP_WRITE: return write_data;
            default:   return regs_q[a];
        endcase
    endfunction

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] rd_q;

        assign w_addr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_ff @(posedge clock) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= capture_word(w_addr);
            end
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

    assign w_dump_word = capture_word(w_dump_req_idx);

    regfile_dump_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dump_ctrl (
        .clock       (clock),
        .reset       (reset),
        .dump_start  (dump_start),
        .dump_ready  (dump_ready),
        .req_index_o (w_dump_req_idx),
        .req_word_i  (w_dump_word),
        .dump_busy   (dump_busy),
        .dump_valid  (dump_valid),
        .dump_index  (dump_index),
        .dump_data   (dump_data),
        .dump_done   (dump_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// tb_regfile_param : randomized bench for regfile_param against a reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int RAW   = NR * AW;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [RAW-1:0] read_addr = '0;
    logic           reg_write = 1'b0;
    logic [AW-1:0]  write_address = '0;
    logic [DW-1:0]  write_data = '0;
    logic           dump_start = 1'b0;
    logic           dump_ready = 1'b0;

    logic [NR*DW-1:0] read_data1, read_data0;
    logic             dump_busy, dump_valid, dump_done;
    logic [AW-1:0]    dump_index;
    logic [DW-1:0]    dump_data;
    logic             d0_busy, d0_valid, d0_done;
    logic [AW-1:0]    d0_index;
    logic [DW-1:0]    d0_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_busy   = 0;
    int n_done   = 0;

    always #5 clock = ~clock;

    regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(read_data1),
        .reg_write(reg_write), .write_address(write_address), .write_data(write_data),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_index(dump_index), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(read_data0),
        .reg_write(reg_write), .write_address(write_address), .write_data(write_data),
        .dump_start(1'b0), .dump_busy(d0_busy), .dump_valid(d0_valid),
        .dump_ready(1'b0), .dump_index(d0_index), .dump_data(d0_data),
        .dump_done(d0_done)
    );

    // Reference state: mem1 for ZERO_REG=1/BYPASS=1, mem0 for ZERO_REG=0/BYPASS=0
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] e1 [NR];
    logic [DW-1:0] e0 [NR];
    bit            m_busy, m_valid, m_done;
    logic [AW-1:0] m_idx = '0;
    logic [DW-1:0] m_data = '0;
    int            q_idx[$];
    logic [DW-1:0] q_dat[$];

    function automatic logic [DW-1:0] ref1(input int a);
        if (a == 0) return '0;
        if (reg_write && int'(write_address) == a) return write_data;
        return mem1[a];
    endfunction

    function automatic logic [DW-1:0] ref0(input int a);
        return mem0[a];
    endfunction

    always @(posedge clock) begin
        if (!reset && dump_valid && dump_ready) begin
            q_idx.push_back(int'(dump_index));
            q_dat.push_back(dump_data);
        end
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem1[i] = '0;
                mem0[i] = '0;
            end
            for (int p = 0; p < NR; p++) begin
                e1[p] = '0;
                e0[p] = '0;
            end
            m_busy = 0; m_valid = 0; m_done = 0; m_idx = '0; m_data = '0;
        end else begin
            for (int p = 0; p < NR; p++) begin
                e1[p] = ref1(int'(read_addr[p*AW +: AW]));
                e0[p] = ref0(int'(read_addr[p*AW +: AW]));
            end
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (dump_start) begin
                    m_busy = 1; m_valid = 1; m_idx = '0; m_data = ref1(0);
                end
            end else if (m_valid && dump_ready) begin
                if (m_idx == 5'd31) begin
                    m_valid = 0; m_done = 1; m_idx = '0;
                end else begin
                    m_idx  = m_idx + 5'd1;
                    m_data = ref1(int'(m_idx));
                end
            end
            if (reg_write && write_address != '0) mem1[write_address] = write_data;
            if (reg_write) mem0[write_address] = write_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        for (int p = 0; p < NR; p++) begin
            check_eq($sformatf("rd_zb_p%0d", p), read_data1[p*DW +: DW], e1[p]);
            check_eq($sformatf("rd_nb_p%0d", p), read_data0[p*DW +: DW], e0[p]);
        end
        check_eq("dump_valid", 32'(dump_valid), 32'(m_valid));
        check_eq("dump_busy",  32'(dump_busy),  32'(m_busy));
        check_eq("dump_done",  32'(dump_done),  32'(m_done));
        check_eq("dump_index", 32'(dump_index), 32'(m_idx));
        check_eq("dump_data",  dump_data,       m_data);
        check_eq("nb_idle",    32'(d0_busy),    32'd0);
        if (dump_busy) n_busy++;
        if (dump_done) n_done++;
    endtask

    initial begin
        logic [DW-1:0] held;
        bit            stalled;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Everything reads zero after reset
        for (int a = 0; a < DEPTH; a++) begin
            read_addr = {AW'(DEPTH - 1 - a), AW'(a)};
            tick();
        end
        check_eq("rst_busy", 32'(dump_busy), 32'd0);
        check_eq("rst_valid", 32'(dump_valid), 32'd0);

        // Directed writes and reads
        reg_write = 1'b1; write_address = 5'd1; write_data = 32'd10;
        tick();
        write_address = 5'd5; write_data = 32'hFFFF_FFFB;
        tick();
        reg_write = 1'b0; read_addr = {5'd5, 5'd1};
        tick();
        check_eq("read_r1", read_data1[0 +: DW], 32'h0000_000A);
        check_eq("read_r5", read_data1[DW +: DW], 32'hFFFF_FFFB);
        reg_write = 1'b1; write_address = 5'd0; write_data = 32'd7;
        tick();
        reg_write = 1'b0; read_addr = {5'd0, 5'd0};
        tick();
        check_eq("zero_reg_r0", read_data1[0 +: DW], 32'd0);
        check_eq("plain_r0", read_data0[0 +: DW], 32'd7);

        // Same-edge write and read of register 3
        reg_write = 1'b1; write_address = 5'd3; write_data = 32'h1234; read_addr = {5'd3, 5'd3};
        tick();
        check_eq("bypass_on", read_data1[0 +: DW], 32'h1234);
        check_eq("bypass_off_old", read_data0[0 +: DW], 32'd0);
        reg_write = 1'b0;
        tick();
        check_eq("bypass_off_new", read_data0[0 +: DW], 32'h1234);

        // Random traffic on the read and write ports
        for (int c = 0; c < 300; c++) begin
            reg_write     = 1'($urandom_range(0, 1));
            write_address = AW'($urandom);
            write_data    = $urandom;
            read_addr     = RAW'($urandom);
            if ($urandom_range(0, 3) == 0) read_addr[AW-1:0] = write_address;
            tick();
        end

        // Load reg n = n + 100, then a free-running dump
        for (int n = 0; n < DEPTH; n++) begin
            reg_write = 1'b1; write_address = AW'(n); write_data = DW'(n + 100);
            tick();
        end
        reg_write = 1'b0;
        dump_ready = 1'b1;
        q_idx.delete(); q_dat.delete();
        n_busy = 0; n_done = 0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int c = 0; c < 100 && dump_busy; c++) tick();
        check_eq("dump1_end", 32'(dump_busy), 32'd0);
        check_eq("dump1_busy_cycles", 32'(n_busy), 32'd33);
        check_eq("dump1_done_pulses", 32'(n_done), 32'd1);
        check_eq("dump1_words", 32'(q_idx.size()), 32'd32);
        for (int i = 0; i < q_idx.size(); i++) begin
            check_eq($sformatf("dump1_idx%0d", i), 32'(q_idx[i]), 32'(i));
            check_eq($sformatf("dump1_dat%0d", i), q_dat[i], (i == 0) ? 32'd0 : 32'(i + 100));
        end

        // Dump under back-pressure with concurrent writes and repeated starts
        q_idx.delete(); q_dat.delete();
        n_done = 0; stalled = 0;
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        for (int c = 0; c < 600 && dump_busy; c++) begin
            dump_start    = 1'($urandom_range(0, 1));
            dump_ready    = 1'($urandom_range(0, 1));
            reg_write     = 1'($urandom_range(0, 1));
            write_address = ($urandom_range(0, 1) == 1) ? dump_index : AW'($urandom);
            write_data    = $urandom;
            read_addr     = RAW'($urandom);
            if (!stalled && dump_valid && q_idx.size() == 5) begin
                stalled = 1;
                held = m_data;
                dump_ready = 1'b0; reg_write = 1'b1;
                write_address = dump_index; write_data = 32'hDEAD;
                tick();
                check_eq("stall_hold", dump_data, held);
            end else begin
                tick();
            end
        end
        dump_start = 1'b0; reg_write = 1'b0;
        check_eq("dump2_end", 32'(dump_busy), 32'd0);
        check_eq("dump2_done_pulses", 32'(n_done), 32'd1);
        check_eq("dump2_words", 32'(q_idx.size()), 32'd32);
        for (int i = 0; i < q_idx.size(); i++) begin
            check_eq($sformatf("dump2_idx%0d", i), 32'(q_idx[i]), 32'(i));
        end

        // Reset in the middle of a dump
        reg_write = 1'b1; write_address = 5'd7; write_data = 32'd77;
        tick();
        reg_write = 1'b0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int c = 0; c < 50 && m_idx != 5'd10; c++) tick();
        check_eq("wait_idx10", 32'(dump_index), 32'd10);
        n_done = 0;
        reset = 1'b1;
        tick();
        check_eq("abort_valid", 32'(dump_valid), 32'd0);
        check_eq("abort_busy", 32'(dump_busy), 32'd0);
        reset = 1'b0;
        dump_ready = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            read_addr = {AW'(a), AW'(a)};
            tick();
            check_eq($sformatf("abort_clear%0d", a), read_data0[DW +: DW], 32'd0);
        end
        check_eq("abort_no_done", 32'(n_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
